// File: rtl/div_unit_if.sv
// div_unit_if: divider handshake and operand/result bundle between control unit and div_unit.
interface div_unit_if #(parameter int WIDTH = 32);
  logic             DivCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivOut;
  logic             divZero;
  modport master (output DivCtrl, A, B, input HI, LO, DivOut, divZero);
  modport slave  (input DivCtrl, A, B, output HI, LO, DivOut, divZero);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring signed divider, quotient to LO, remainder to HI.
// Optional DIV_EARLY_EXIT_EN skips iteration when |A| < |B|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             aneg_q, aneg_d;
  logic             qneg_q, qneg_d;
  logic             zflag_q, zflag_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_mag;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  assign a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign b_mag = bus.B[WIDTH-1] ? -{1'b1, bus.B} : {1'b0, bus.B};
  assign sh    = {rem_q, quo_q[WIDTH-1]};
  assign diff  = sh - dvs_q;
  // sh < 2*|B|, so the borrow bit alone tells whether the subtraction fits
  assign ge    = ~diff[WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    aneg_d  = aneg_q;
    qneg_d  = qneg_q;
    zflag_d = 1'b0;
    done_d  = 1'b0;
    dz_d    = zflag_q;
    case (state_q)
      IDLE: begin
        if (bus.DivCtrl) begin
          if (bus.B == '0) begin
            zflag_d = 1'b1;
            state_d = HOLD;
          end else begin
            dvs_d   = b_mag;
            aneg_d  = bus.A[WIDTH-1];
            qneg_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            rem_d   = '0;
            quo_d   = a_mag;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
`ifdef DIV_EARLY_EXIT_EN
            if ({1'b0, a_mag} < b_mag) begin
              rem_d   = a_mag;
              quo_d   = '0;
              state_d = DONE;
            end
`endif
          end
        end
      end
      CALC: begin
        rem_d   = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
        cnt_d   = cnt_q - CW'(cnt_q != '0);
        state_d = (cnt_q == '0) ? DONE : CALC;
      end
      DONE: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = aneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = HOLD;
      end
      default: state_d = bus.DivCtrl ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      aneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      zflag_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      aneg_q  <= aneg_d;
      qneg_q  <= qneg_d;
      zflag_q <= zflag_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.DivOut  = done_q;
  assign bus.divZero = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = 33;
`endif
  div_unit_if #(.WIDTH(32)) bus ();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output int first, output int np, output int zfirst, output int nz);
    first = 0; np = 0; zfirst = 0; nz = 0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.DivCtrl = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (bus.DivOut) begin np++; if (first == 0) first = k; end
      if (bus.divZero) begin nz++; if (zfirst == 0) zfirst = k; end
      bus.A = 32'hDEAD_BEEF; bus.B = 32'h0;
    end
    @(negedge clk);
    bus.DivCtrl = 1'b0;
    @(posedge clk);
  endtask
  task automatic test_reset();
    bus.DivCtrl = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.HI); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.LO); end
    checks++; if (bus.DivOut !== 1'b0) begin errors++; $display("FAIL reset_divout got %b want 0", bus.DivOut); end
    checks++; if (bus.divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", bus.divZero); end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_signed();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] el [3];
    logic [31:0] eh [3];
    int f, n, zf, zn;
    va = '{32'd100, 32'hFFFF_FF9C, 32'd100};
    vb = '{32'd7, 32'd7, 32'hFFFF_FFF9};
    el = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2};
    eh = '{32'd2, 32'hFFFF_FFFE, 32'd2};
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], 40, f, n, zf, zn);
      checks++; if (f !== 33) begin errors++; $display("FAIL signed%0d_latency got %0d want 33", i, f); end
      checks++; if (n !== 1) begin errors++; $display("FAIL signed%0d_pulses got %0d want 1", i, n); end
      checks++; if (bus.LO !== el[i]) begin errors++; $display("FAIL signed%0d_lo got %h want %h", i, bus.LO, el[i]); end
      checks++; if (bus.HI !== eh[i]) begin errors++; $display("FAIL signed%0d_hi got %h want %h", i, bus.HI, eh[i]); end
    end
  endtask
  task automatic test_overflow();
    int f, n, zf, zn;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 40, f, n, zf, zn);
    checks++; if (n !== 1) begin errors++; $display("FAIL ovf_m1_pulses got %0d want 1", n); end
    checks++; if (bus.LO !== 32'h8000_0000) begin errors++; $display("FAIL ovf_m1_lo got %h want 80000000", bus.LO); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL ovf_m1_hi got %h want 0", bus.HI); end
    run_div(32'h8000_0000, 32'd1, 40, f, n, zf, zn);
    checks++; if (bus.LO !== 32'h8000_0000) begin errors++; $display("FAIL ovf_p1_lo got %h want 80000000", bus.LO); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL ovf_p1_hi got %h want 0", bus.HI); end
  endtask
  task automatic test_div_zero();
    int f, n, zf, zn;
    run_div(32'd100, 32'd7, 40, f, n, zf, zn);
    run_div(32'd5, 32'd0, 40, f, n, zf, zn);
    checks++; if (zf !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", zf); end
    checks++; if (zn !== 1) begin errors++; $display("FAIL dz_pulses got %0d want 1", zn); end
    checks++; if (n !== 0) begin errors++; $display("FAIL dz_divout got %0d want 0", n); end
    checks++; if (bus.HI !== 32'd2) begin errors++; $display("FAIL dz_hi_kept got %h want 2", bus.HI); end
    checks++; if (bus.LO !== 32'd14) begin errors++; $display("FAIL dz_lo_kept got %h want e", bus.LO); end
  endtask
  task automatic test_back_to_back();
    int f, n, zf, zn;
    run_div(32'd1000, 32'd10, 50, f, n, zf, zn);
    checks++; if (n !== 1) begin errors++; $display("FAIL hold50_pulses got %0d want 1", n); end
    checks++; if (bus.LO !== 32'd100) begin errors++; $display("FAIL hold50_lo got %h want 64", bus.LO); end
    run_div(32'd9, 32'd3, 40, f, n, zf, zn);
    checks++; if (f !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", f); end
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", n); end
    checks++; if (bus.LO !== 32'd3) begin errors++; $display("FAIL b2b_lo got %h want 3", bus.LO); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL b2b_hi got %h want 0", bus.HI); end
  endtask
  task automatic test_reset_abort();
    int n = 0;
    @(negedge clk);
    bus.A = 32'd77; bus.B = 32'd5; bus.DivCtrl = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus.DivCtrl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.DivOut) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", n); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL abort_lo got %h want 0", bus.LO); end
    checks++; if (bus.HI !== 32'd0) begin errors++; $display("FAIL abort_hi got %h want 0", bus.HI); end
  endtask
  task automatic test_early_exit();
    int f, n, zf, zn;
    run_div(32'd3, 32'd10, 40, f, n, zf, zn);
    checks++; if (f !== LAT_SHORT) begin errors++; $display("FAIL early_latency got %0d want %0d", f, LAT_SHORT); end
    checks++; if (n !== 1) begin errors++; $display("FAIL early_pulses got %0d want 1", n); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL early_lo got %h want 0", bus.LO); end
    checks++; if (bus.HI !== 32'd3) begin errors++; $display("FAIL early_hi got %h want 3", bus.HI); end
    run_div(32'hFFFF_FFFD, 32'd10, 40, f, n, zf, zn);
    checks++; if (f !== LAT_SHORT) begin errors++; $display("FAIL early_neg_latency got %0d want %0d", f, LAT_SHORT); end
    checks++; if (bus.LO !== 32'd0) begin errors++; $display("FAIL early_neg_lo got %h want 0", bus.LO); end
    checks++; if (bus.HI !== 32'hFFFF_FFFD) begin errors++; $display("FAIL early_neg_hi got %h want fffffffd", bus.HI); end
  endtask
  initial begin
    test_reset();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_early_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
